sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 8-bit asynchronous SRAM between two
// requesters. r0 (video fetch) has fixed priority; r1 (CPU/DMA) is forced
// through after STARVE_LIMIT consecutive lost contests.
// Optional build macro: SRAM_ARB_ROUNDROBIN_EN. When defined, contests are
// decided by a last-grant flag (alternating) and the starve counter is dropped.
// Every SRAM-side output is driven straight from a flop so the pins never glitch.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request; bus released, write strobe high
// ACCESS  | cnt = 0 address setup, cnt >= 1 write strobe low (writes only)
// RECOVER | strobe high, address/drive held for hold time, ack the winner

module sram_arbiter #(
    parameter int AW            = 21,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [7:0]    r0_wdata,
    output logic [7:0]    r0_rdata,
    output logic          r0_ack,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [7:0]    r1_wdata,
    output logic [7:0]    r1_rdata,
    output logic          r1_ack,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_data_o,
    output logic          sram_data_oe,
    input  logic [7:0]    sram_data_i,
    output logic          sram_we_n,
    output logic          busy
);

    localparam int CW = $clog2(ACCESS_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic          grant_r1_q;
`ifdef SRAM_ARB_ROUNDROBIN_EN
    logic          last_r1_q;
`else
    logic [7:0]    starve_q;
`endif

    logic          both_req;
    logic          pick_r1_d;
    logic          sel_we_d;
    logic [AW-1:0] sel_addr_d;
    logic [7:0]    sel_wdata_d;

    // Winner selection for the IDLE grant and a mux of the winner's request fields.
    always_comb begin
        both_req = r0_req & r1_req;
`ifdef SRAM_ARB_ROUNDROBIN_EN
        pick_r1_d = both_req ? ~last_r1_q : r1_req;
`else
        pick_r1_d = both_req ? (starve_q == 8'(STARVE_LIMIT)) : r1_req;
`endif
        sel_we_d    = pick_r1_d ? r1_we    : r0_we;
        sel_addr_d  = pick_r1_d ? r1_addr  : r0_addr;
        sel_wdata_d = pick_r1_d ? r1_wdata : r0_wdata;
    end

    // Access sequencer with registered SRAM pins, acks and read data.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            grant_r1_q   <= 1'b0;
`ifdef SRAM_ARB_ROUNDROBIN_EN
            last_r1_q    <= 1'b1;
`else
            starve_q     <= 8'd0;
`endif
            sram_addr    <= '0;
            sram_data_o  <= 8'd0;
            sram_data_oe <= 1'b0;
            sram_we_n    <= 1'b1;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rdata     <= 8'd0;
            r1_rdata     <= 8'd0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    sram_data_oe <= 1'b0;
                    sram_we_n    <= 1'b1;
                    if (r0_req || r1_req) begin
                        grant_r1_q   <= pick_r1_d;
                        we_q         <= sel_we_d;
                        sram_addr    <= sel_addr_d;
                        sram_data_o  <= sel_wdata_d;
                        sram_data_oe <= sel_we_d;
                        cnt_q        <= '0;
                        state_q      <= ACCESS;
`ifdef SRAM_ARB_ROUNDROBIN_EN
                        last_r1_q    <= pick_r1_d;
`else
                        if (pick_r1_d) begin
                            starve_q <= 8'd0;
                        end else if (both_req && starve_q != 8'hFF) begin
                            starve_q <= starve_q + 8'd1;
                        end
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q == CW'(ACCESS_CYCLES - 1)) begin
                        sram_we_n <= 1'b1;
                        state_q   <= RECOVER;
                        if (grant_r1_q) begin
                            r1_ack <= 1'b1;
                            if (!we_q) r1_rdata <= sram_data_i;
                        end else begin
                            r0_ack <= 1'b1;
                            if (!we_q) r0_rdata <= sram_data_i;
                        end
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                        sram_we_n <= ~we_q;
                    end
                end
                RECOVER: begin
                    sram_we_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    sram_we_n    <= 1'b1;
                    sram_data_oe <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed write/read/back-to-back/reset/idle cases and
// a contention run, with an ack-order and read-data scoreboard.
module tb_sram_arbiter;

    localparam int AW = 21;

    logic          sysclk = 1'b0;
    logic          rst;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [7:0]    r0_wdata, r1_wdata;
    logic [7:0]    r0_rdata, r1_rdata;
    logic          r0_ack, r1_ack;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_data_o, sram_data_i;
    logic          sram_data_oe, sram_we_n, busy;

    always #5 sysclk = ~sysclk;

    sram_arbiter dut (
        .sysclk(sysclk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ack(r1_ack),
        .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
        .sram_data_i(sram_data_i), .sram_we_n(sram_we_n), .busy(busy)
    );

    // SRAM model: low address byte selects a cell; unwritten cells hold a fixed pattern.
    bit [7:0] mem [256];
    bit       wr_flag [256];

    function automatic logic [7:0] sram_read(input logic [7:0] a);
        if (wr_flag[a]) return mem[a];
        return (a == 8'h10) ? 8'hC3 : (a ^ 8'hA5);
    endfunction

    assign sram_data_i = sram_read(sram_addr[7:0]);

    always @(posedge sysclk) begin
        if (!sram_we_n && sram_data_oe) begin
            mem[sram_addr[7:0]]     <= sram_data_o;
            wr_flag[sram_addr[7:0]] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       id;
        logic       we;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic id, input logic we, input logic [7:0] rd);
        exp_t e;
        e.id = id; e.we = we; e.rd = rd;
        sb.push_back(e);
    endtask

    // Scoreboard: every ack must match the next expected grant and its read data.
    always @(negedge sysclk) begin
        exp_t e;
        if (r0_ack && r1_ack) check("dual_ack", 1, 0);
        if (r0_ack || r1_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ack_id", r1_ack, e.id);
                if (!e.we) check("ack_rdata", r1_ack ? r1_rdata : r0_rdata, e.rd);
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_r0(input logic req, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    task automatic wait_ack(input logic id, input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!(id ? r1_ack : r0_ack) && waited < budget);
        check($sformatf("ack_seen_r%0d", id), id ? r1_ack : r0_ack, 1);
    endtask

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    rd;
    } op_t;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        op_t ops [4];
        int  w, last_ack, n;

        rst = 1'b1;
        set_r0(0, 0, '0, 8'h00);
        set_r1(0, 0, '0, 8'h00);
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_data_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_data_o", sram_data_o, 0);
        check("rst_acks", {r0_ack, r1_ack}, 0);
        check("rst_rdata", {r0_rdata, r1_rdata}, 0);
        rst = 1'b0;
        tick();

        // Single write by r1.
        set_r1(1, 1, 21'h1ABCD, 8'h5A);
        push_exp(1, 1, 8'h00);
        tick();
        check("wr_c0_addr", sram_addr, 21'h1ABCD);
        check("wr_c0_we_n", sram_we_n, 1);
        check("wr_c0_oe", sram_data_oe, 1);
        check("wr_c0_data", sram_data_o, 8'h5A);
        check("wr_c0_busy", busy, 1);
        check("wr_c0_ack", r1_ack, 0);
        tick();
        check("wr_c1_addr", sram_addr, 21'h1ABCD);
        check("wr_c1_we_n", sram_we_n, 0);
        check("wr_c1_oe", sram_data_oe, 1);
        check("wr_c1_ack", r1_ack, 0);
        tick();
        check("wr_rec_addr", sram_addr, 21'h1ABCD);
        check("wr_rec_we_n", sram_we_n, 1);
        check("wr_rec_oe", sram_data_oe, 1);
        check("wr_rec_ack", r1_ack, 1);
        tick();
        check("wr_idle_ack", r1_ack, 0);
        check("wr_idle_busy", busy, 0);
        check("wr_idle_oe", sram_data_oe, 0);
        set_r1(0, 0, '0, 8'h00);

        // Single read by r0.
        set_r0(1, 0, 21'h00010, 8'h00);
        push_exp(0, 0, 8'hC3);
        tick();
        check("rd_c0_oe", sram_data_oe, 0);
        check("rd_c0_addr", sram_addr, 21'h00010);
        tick();
        check("rd_c1_oe", sram_data_oe, 0);
        check("rd_c1_we_n", sram_we_n, 1);
        tick();
        check("rd_rec_ack", r0_ack, 1);
        check("rd_rec_rdata", r0_rdata, 8'hC3);
        check("rd_rec_oe", sram_data_oe, 0);
        tick();
        set_r0(0, 0, '0, 8'h00);
        check("rd_hold_rdata", r0_rdata, 8'hC3);
        check("rd_r1_rdata", r1_rdata, 8'h00);

        // Back-to-back r0 accesses with req held across acks.
        ops[0] = '{we: 1'b0, a: 21'h1ABCD, d: 8'h00, rd: 8'h5A};
        ops[1] = '{we: 1'b0, a: 21'h00010, d: 8'h00, rd: 8'hC3};
        ops[2] = '{we: 1'b1, a: 21'h00020, d: 8'h77, rd: 8'h00};
        ops[3] = '{we: 1'b0, a: 21'h00020, d: 8'h00, rd: 8'h77};
        last_ack = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            set_r0(1, ops[i].we, ops[i].a, ops[i].d);
            push_exp(0, ops[i].we, ops[i].rd);
            wait_ack(0, 10, w);
            check($sformatf("b2b_latency_%0d", i), w, 3);
            if (i > 0) check($sformatf("b2b_spacing_%0d", i), cyc - last_ack, 4);
            last_ack = cyc;
        end
        tick();
        set_r0(0, 0, '0, 8'h00);
        repeat (2) tick();

        // Reset during the write-strobe cycle aborts without an ack.
        set_r0(1, 1, 21'h00030, 8'h99);
        tick();
        tick();
        check("rstw_pre_we_n", sram_we_n, 0);
        rst = 1'b1;
        tick();
        check("rstw_we_n", sram_we_n, 1);
        check("rstw_oe", sram_data_oe, 0);
        check("rstw_busy", busy, 0);
        check("rstw_ack", {r0_ack, r1_ack}, 0);
        check("rstw_rdata", r0_rdata, 0);
        rst = 1'b0;
        set_r0(0, 0, '0, 8'h00);
        repeat (3) tick();
        check("rstw_late_ack", {r0_ack, r1_ack}, 0);

        // Idle: nothing moves for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle", {busy, sram_we_n, sram_data_oe, r0_ack, r1_ack}, 5'b01000);
        end

        // Contention: both requesters hold req continuously.
        for (int k = 0; k < 18; k++) begin
`ifdef SRAM_ARB_ROUNDROBIN_EN
            if (k % 2 == 1) push_exp(1, 0, 8'h5A);
            else            push_exp(0, 0, 8'hC3);
`else
            if (k % 9 == 8) push_exp(1, 0, 8'h5A);
            else            push_exp(0, 0, 8'hC3);
`endif
        end
        set_r0(1, 0, 21'h00010, 8'h00);
        set_r1(1, 0, 21'h1ABCD, 8'h00);
        n = 0;
        for (int c = 0; c < 200 && n < 18; c++) begin
            tick();
            if (r0_ack || r1_ack) n++;
        end
        check("cont_ack_count", n, 18);
        tick();
        set_r0(0, 0, '0, 8'h00);
        set_r1(0, 0, '0, 8'h00);
        repeat (10) tick();
        check("final_busy", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
